// File: rtl/i2c_cmd_sequencer.sv
// Register-level command front-end for the I2C master: issue, await done, retry on NACK, respond.
// Optional watchdog on each attempt is enabled with `define I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
  parameter int ADDR_BYTES  = 1,
  parameter int DATA_BYTES  = 2,
  parameter int ST_WIDTH    = 1 + ADDR_BYTES + DATA_BYTES,
  parameter int MAX_RETRIES = 3,
  parameter int RETRY_GAP   = 64,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [6:0]              cmd_chip_addr,
  input  logic [8*ADDR_BYTES-1:0] cmd_reg_addr,
  input  logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_nack,
  output logic                    rsp_timeout,
  output logic [3:0]              rsp_attempts,
  output logic [6:0]              m_chip_addr,
  output logic [8*ADDR_BYTES-1:0] m_reg_addr,
  output logic [8*DATA_BYTES-1:0] m_data_in,
  output logic                    m_write_en,
  output logic                    m_read_en,
  output logic                    m_write_mode,
  input  logic [8*DATA_BYTES-1:0] m_data_out,
  input  logic [ST_WIDTH-1:0]     m_status,
  input  logic                    m_done,
  input  logic                    m_busy
);

  localparam int GAP_W = $clog2(RETRY_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RETRY_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [4:0]       MAX_R    = 5'(MAX_RETRIES);

  if (RETRY_GAP < 1) begin : g_bad_gap
    $error("RETRY_GAP must be at least 1");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retries
    $error("MAX_RETRIES must be in 0..15");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DONE, S_CHECK, S_GAP, S_RESP
  } state_t;

  state_t           state;
  logic             rw_q;
  logic             nack_q;
  logic [GAP_W-1:0] gap_cnt;

  assign m_write_mode = 1'b0;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_nack     <= 1'b0;
      rsp_attempts <= '0;
      m_write_en   <= 1'b0;
      m_read_en    <= 1'b0;
      m_chip_addr  <= '0;
      m_reg_addr   <= '0;
      m_data_in    <= '0;
      rw_q         <= 1'b0;
      nack_q       <= 1'b0;
      gap_cnt      <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      rsp_timeout  <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      // enables are single-cycle pulses; only ISSUE raises them
      m_write_en <= 1'b0;
      m_read_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            rw_q         <= cmd_rw;
            m_chip_addr  <= cmd_chip_addr;
            m_reg_addr   <= cmd_reg_addr;
            m_data_in    <= cmd_wdata;
            rsp_attempts <= 4'd1;
            rsp_rdata    <= '0;
            rsp_nack     <= 1'b0;
            cmd_ready    <= 1'b0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!m_busy) begin
            m_write_en <= !rw_q;
            m_read_en  <= rw_q;
            state      <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (m_done) begin
            nack_q <= |m_status;
            if (rw_q) rsp_rdata <= m_data_out;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (nack_q && ({1'b0, rsp_attempts} <= MAX_R)) begin
            rsp_attempts <= rsp_attempts + 4'd1;
            gap_cnt      <= GAP_LOAD;
            state        <= S_GAP;
          end else begin
            rsp_nack  <= nack_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - GAP_ONE;
          if (gap_cnt == GAP_ONE) state <= S_ISSUE;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef I2C_SEQ_TIMEOUT_EN
      // watchdog placed after the case so an expiry overrides that cycle's FSM update
      if ((state == S_IDLE && cmd_valid && cmd_ready) ||
          (state == S_GAP && gap_cnt == GAP_ONE)) begin
        wd_cnt <= '0;
        if (state == S_IDLE) rsp_timeout <= 1'b0;
      end else if (state == S_ISSUE || state == S_WAIT_DONE) begin
        if (wd_cnt == WD_LAST) begin
          m_write_en  <= 1'b0;
          m_read_en   <= 1'b0;
          rsp_timeout <= 1'b1;
          rsp_nack    <= 1'b1;
          rsp_valid   <= 1'b1;
          state       <= S_RESP;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: randomized commands, behavioural master model and response monitor.
module tb_i2c_cmd_sequencer;
  localparam int ADDR_BYTES  = 1;
  localparam int DATA_BYTES  = 2;
  localparam int ST_WIDTH    = 4;
  localparam int MAX_RETRIES = 3;
  localparam int RETRY_GAP   = 64;
  localparam int TIMEOUT_CYC = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [6:0]  cmd_chip_addr;
  logic [7:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_nack, rsp_timeout;
  logic [3:0]  rsp_attempts;
  logic [6:0]  m_chip_addr;
  logic [7:0]  m_reg_addr;
  logic [15:0] m_data_in;
  logic        m_write_en, m_read_en, m_write_mode;
  logic [15:0] m_data_out;
  logic [3:0]  m_status;
  logic        m_done, m_busy;

  // master-model and driver contributions are kept separate and merged
  logic        busy_m, busy_d, done_m, done_d;
  logic [3:0]  st_m, st_d;
  logic [15:0] dout_m, dout_d;
  assign m_busy     = busy_m | busy_d;
  assign m_done     = done_m | done_d;
  assign m_status   = st_m | st_d;
  assign m_data_out = dout_m | dout_d;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(
    .ADDR_BYTES(ADDR_BYTES), .DATA_BYTES(DATA_BYTES), .ST_WIDTH(ST_WIDTH),
    .MAX_RETRIES(MAX_RETRIES), .RETRY_GAP(RETRY_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_chip_addr(cmd_chip_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout), .rsp_attempts(rsp_attempts),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
    .m_write_en(m_write_en), .m_read_en(m_read_en), .m_write_mode(m_write_mode),
    .m_data_out(m_data_out), .m_status(m_status), .m_done(m_done), .m_busy(m_busy)
  );

  typedef struct {
    logic        rw;
    logic [6:0]  chip;
    logic [7:0]  reg_a;
    logic [15:0] wdata;
    logic [3:0]  st;
    logic [15:0] data;
    int          delay;
    int          idx;
    int          lat;
    bit          nodone;
  } att_t;

  typedef struct {
    logic [15:0] rdata;
    logic        nack;
    logic        tmo;
    logic [3:0]  attempts;
    int          pulses;
  } rsp_t;

  att_t mq[$];
  rsp_t sq[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, pulses = 0, exp_pulses = 0;
  int acc_cyc = 0, last_done_cyc = 0;
  int hold_req = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Master model: answers each enable pulse with the next scripted attempt
  initial begin : master
    att_t a;
    busy_m = 1'b0; done_m = 1'b0; st_m = '0; dout_m = '0;
    forever begin
      @(negedge clk);
      if (m_write_en || m_read_en) begin
        pulses++;
        if (mq.size() == 0) begin
          fail_now("unexpected_enable");
        end else begin
          a = mq.pop_front();
          chk("enable_select", 32'({m_write_en, m_read_en}), a.rw ? 32'd1 : 32'd2);
          chk("m_chip_addr", 32'(m_chip_addr), 32'(a.chip));
          chk("m_reg_addr", 32'(m_reg_addr), 32'(a.reg_a));
          chk("m_data_in", 32'(m_data_in), 32'(a.wdata));
          if (a.idx == 0) chk("issue_latency", cyc - acc_cyc, a.lat);
          else            chk("retry_spacing", cyc - last_done_cyc, RETRY_GAP + 3);
          if (!a.nodone) begin
            busy_m = 1'b1;
            repeat (a.delay) @(negedge clk);
            done_m = 1'b1; st_m = a.st; dout_m = a.data; last_done_cyc = cyc;
            @(negedge clk);
            done_m = 1'b0; st_m = '0; dout_m = '0; busy_m = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor: stability under backpressure, then pop-and-compare on handshake
  initial begin : monitor
    rsp_t e;
    logic [31:0] snap, cur;
    bit seen;
    int hold;
    seen = 0; hold = 0; rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      cur = 32'({rsp_rdata, rsp_nack, rsp_timeout, rsp_attempts});
      if (rsp_valid) begin
        chk("cmd_ready_while_resp", 32'(cmd_ready), 32'd0);
        if (!seen) begin
          seen = 1; snap = cur;
          hold = (hold_req >= 0) ? hold_req : $urandom_range(0, 4);
          if (sq.size() > 0) begin
            if (sq[0].tmo) chk("timeout_latency", cyc - acc_cyc, TIMEOUT_CYC);
            else           chk("done_to_rsp_latency", cyc - last_done_cyc, 2);
          end
        end else begin
          chk("rsp_stable", cur, snap);
        end
        if (hold == 0) begin
          rsp_ready = 1'b1;
          seen = 0;
          if (sq.size() == 0) begin
            fail_now("unexpected_response");
          end else begin
            e = sq.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_nack", 32'(rsp_nack), 32'(e.nack));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
            chk("rsp_attempts", 32'(rsp_attempts), 32'(e.attempts));
            chk("enable_pulses", pulses, e.pulses);
            chk("m_write_mode", 32'(m_write_mode), 32'd0);
          end
        end else begin
          rsp_ready = 1'b0;
          hold--;
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  task automatic drive_cmd(input logic rw, input logic [6:0] chip, input logic [7:0] ra,
                           input logic [15:0] wd, input int b);
    int guard;
    cmd_rw = rw; cmd_chip_addr = chip; cmd_reg_addr = ra; cmd_wdata = wd;
    cmd_valid = 1'b1; busy_d = (b > 0);
    guard = 0;
    while (!cmd_ready && guard < 1000) begin @(negedge clk); guard++; end
    if (!cmd_ready) fail_now("cmd_ready_wait");
    @(negedge clk);
    acc_cyc = cyc; cmd_valid = 1'b0;
    repeat (b) @(negedge clk);
    busy_d = 1'b0;
  endtask

  // Reference: k leading NACKs; attempts stop at MAX_RETRIES+1; reads return the last attempt's data
  task automatic send(input logic rw, input logic [6:0] chip, input logic [7:0] ra, input logic [15:0] wd,
                      input int k, input int b, input logic [3:0] nst, input bit fix_rd,
                      input logic [15:0] rd, input bit nodone);
    int n; att_t a; rsp_t r; logic [15:0] last_d;
    n = nodone ? 1 : ((k > MAX_RETRIES) ? MAX_RETRIES + 1 : k + 1);
    last_d = '0;
    for (int i = 0; i < n; i++) begin
      a.rw = rw; a.chip = chip; a.reg_a = ra; a.wdata = wd;
      a.idx = i; a.lat = b + 1; a.nodone = nodone;
      a.st = (i < k) ? ((nst != 0) ? nst : 4'($urandom_range(1, 15))) : 4'd0;
      a.data = fix_rd ? rd : 16'($urandom);
      a.delay = $urandom_range(0, 6);
      last_d = a.data;
      mq.push_back(a);
    end
    exp_pulses += n;
    r.rdata = (rw && !nodone) ? last_d : 16'd0;
    r.nack = nodone || (k > MAX_RETRIES);
    r.tmo = nodone;
    r.attempts = 4'(n);
    r.pulses = exp_pulses;
    sq.push_back(r);
    drive_cmd(rw, chip, ra, wd, b);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (sq.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
    if (sq.size() != 0) begin
      fail_now("response_wait");
      sq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_nack", 32'(rsp_nack), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_rsp_attempts", 32'(rsp_attempts), 32'd0);
    chk("rst_enables", 32'({m_write_en, m_read_en}), 32'd0);
    chk("rst_m_chip_addr", 32'(m_chip_addr), 32'd0);
    chk("rst_m_reg_addr", 32'(m_reg_addr), 32'd0);
    chk("rst_m_data_in", 32'(m_data_in), 32'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL global_time_limit (cycle %0d)", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin : driver
    att_t a;
    int guard;
    reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0;
    cmd_chip_addr = '0; cmd_reg_addr = '0; cmd_wdata = '0;
    busy_d = 1'b0; done_d = 1'b0; st_d = '0; dout_d = '0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    reset = 1'b1;
    @(negedge clk);

    // directed: write with 10-cycle response backpressure, read, one NACK, persistent NACK
    hold_req = 10;
    send(1'b0, 7'h48, 8'h01, 16'hA55A, 0, 0, 4'd0, 1'b0, 16'd0, 1'b0);
    wait_idle();
    hold_req = -1;
    send(1'b1, 7'h48, 8'h00, 16'h0000, 0, 0, 4'd0, 1'b1, 16'h1234, 1'b0);
    wait_idle();
    send(1'b0, 7'h48, 8'h02, 16'h00FF, 1, 0, 4'b0100, 1'b0, 16'd0, 1'b0);
    wait_idle();
    send(1'b0, 7'h50, 8'h10, 16'hBEEF, 4, 2, 4'd0, 1'b0, 16'd0, 1'b0);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        done_d = 1'b1; st_d = 4'hF; dout_d = 16'($urandom);
        @(negedge clk);
        done_d = 1'b0; st_d = '0; dout_d = '0;
      end
      send(1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom),
           $urandom_range(0, 5), $urandom_range(0, 3), 4'd0, 1'b0, 16'd0, 1'b0);
      wait_idle();
    end

    // reset while waiting for done: command abandoned, late done ignored, no response
    a.rw = 1'b0; a.chip = 7'h48; a.reg_a = 8'h05; a.wdata = 16'h1111;
    a.st = '0; a.data = '0; a.delay = 20; a.idx = 0; a.lat = 1; a.nodone = 1'b0;
    mq.push_back(a);
    exp_pulses++;
    drive_cmd(1'b0, 7'h48, 8'h05, 16'h1111, 0);
    guard = 0;
    while (pulses != exp_pulses && guard < 100) begin @(negedge clk); guard++; end
    if (pulses != exp_pulses) fail_now("reset_test_pulse_wait");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state();
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);

    send(1'b1, 7'h22, 8'h33, 16'h0000, 2, 1, 4'd0, 1'b0, 16'd0, 1'b0);
    wait_idle();

`ifdef I2C_SEQ_TIMEOUT_EN
    send(1'b0, 7'h48, 8'h07, 16'h7777, 0, 0, 4'd0, 1'b0, 16'd0, 1'b1);
    wait_idle();
`endif

    repeat (5) @(negedge clk);
    chk("attempt_queue_drained", 32'(mq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
